// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared FSM encoding and cycle-count helpers for the ultrasonic ranger
package ultrasonic_pkg;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, FAIL, HOLDOFF} state_t;

    function automatic int us2cyc(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchroniser for the raw echo with registered rise/fall pulses
module echo_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_d;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
            fall   <= ~sync & sync_d;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: periodic HC-SR04 trigger, echo timing and distance-in-cm publication
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int CM_US      = 58,
    parameter int TIMEOUT_US = 38_000,
    parameter int PERIOD_US  = 60_000,
    parameter int MAX_CM     = 400
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        echo,
    output logic        trigger,
    output logic [15:0] read_data,
    output logic        read_data_valid,
    output logic        sample_strobe
);

    localparam int TRIG_CYC = us2cyc(CLK_HZ, TRIG_US);
    localparam int CM_CYC   = us2cyc(CLK_HZ, CM_US);
    localparam int TO_CYC   = us2cyc(CLK_HZ, TIMEOUT_US);
    localparam int PER_CYC  = us2cyc(CLK_HZ, PERIOD_US);
    localparam int TW = cnt_w(TRIG_CYC);
    localparam int CW = cnt_w(CM_CYC);
    localparam int OW = cnt_w(TO_CYC);
    localparam int PW = cnt_w(PER_CYC);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYC - 1);
    localparam logic [CW-1:0] CM_LAST   = CW'(CM_CYC - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TO_CYC - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PER_CYC - 1);
    localparam logic [15:0]   MAX_D     = 16'(MAX_CM);

    state_t        state;
    logic          armed;
    logic [TW-1:0] trig_cnt;
    logic [CW-1:0] cm_cnt;
    logic [OW-1:0] to_cnt;
    logic [PW-1:0] per_cnt;
    logic [15:0]   dist_cnt;
    logic [15:0]   dist_nxt;
    logic          echo_lvl;
    logic          echo_rise;
    logic          echo_fall;
    logic          rise_ok;
    logic          fall_ok;
    logic          to_last;
    logic          per_last;
    logic          cm_wrap;

    echo_sync u_echo_sync (
        .clk      (clk),
        .reset_l  (reset_l),
        .async_in (echo),
        .sync     (echo_lvl),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    // an edge pulse is honoured only if the synced level still agrees, rejecting 1-cycle glitches
    always_comb begin
        rise_ok  = echo_rise & echo_lvl;
        fall_ok  = echo_fall & ~echo_lvl;
        to_last  = to_cnt == TO_LAST;
        per_last = per_cnt == PER_LAST;
        cm_wrap  = cm_cnt == CM_LAST;
        dist_nxt = (cm_wrap && dist_cnt != MAX_D) ? dist_cnt + 16'd1 : dist_cnt;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state           <= IDLE;
            armed           <= 1'b0;
            trigger         <= 1'b0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            sample_strobe   <= 1'b0;
            trig_cnt        <= '0;
            cm_cnt          <= '0;
            to_cnt          <= '0;
            per_cnt         <= '0;
            dist_cnt        <= '0;
        end else begin
            sample_strobe <= 1'b0;
            if (!per_last) per_cnt <= per_cnt + 1'b1;
            case (state)
                IDLE: begin
                    armed <= 1'b1;
                    if (armed) begin
                        state    <= TRIG;
                        trigger  <= 1'b1;
                        trig_cnt <= '0;
                        per_cnt  <= '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        state   <= WAIT_RISE;
                        trigger <= 1'b0;
                        to_cnt  <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (!to_last) to_cnt <= to_cnt + 1'b1;
                    if (rise_ok) begin
                        state    <= MEASURE;
                        cm_cnt   <= '0;
                        dist_cnt <= '0;
                    end else if (to_last) begin
                        state           <= FAIL;
                        read_data_valid <= 1'b0;
                        sample_strobe   <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!to_last) to_cnt <= to_cnt + 1'b1;
                    cm_cnt   <= cm_wrap ? '0 : cm_cnt + 1'b1;
                    dist_cnt <= dist_nxt;
                    // the falling-edge cycle itself still counts towards the distance
                    if (fall_ok) begin
                        state           <= DONE;
                        read_data       <= dist_nxt;
                        read_data_valid <= 1'b1;
                        sample_strobe   <= 1'b1;
                    end else if (to_last) begin
                        state           <= FAIL;
                        read_data_valid <= 1'b0;
                        sample_strobe   <= 1'b1;
                    end
                end
                DONE, FAIL: state <= HOLDOFF;
                HOLDOFF: begin
                    if (per_last) begin
                        state    <= TRIG;
                        trigger  <= 1'b1;
                        trig_cnt <= '0;
                        per_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: randomized echo stimulus with a queued scoreboard of expected measurements
module tb_ultrasonic_ranger;

    localparam int CLK_HZ     = 1_000_000;
    localparam int TRIG_US    = 10;
    localparam int CM_US      = 58;
    localparam int TIMEOUT_US = 3000;
    localparam int PERIOD_US  = 4000;
    localparam int MAX_CM     = 40;

    typedef struct {
        bit valid;
        int data;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        echo = 1'b0;
    logic        trigger;
    logic [15:0] read_data;
    logic        read_data_valid;
    logic        sample_strobe;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t popped;
    int   model_data = 0;
    bit   model_valid = 1'b0;
    int   last_pass = 0;
    int   hi_cnt = 0;
    int   last_rise = -1;
    bit   trig_d = 1'b0;

    ultrasonic_ranger #(
        .CLK_HZ     (CLK_HZ),
        .TRIG_US    (TRIG_US),
        .CM_US      (CM_US),
        .TIMEOUT_US (TIMEOUT_US),
        .PERIOD_US  (PERIOD_US),
        .MAX_CM     (MAX_CM)
    ) dut (
        .clk             (clk),
        .reset_l         (reset_l),
        .echo            (echo),
        .trigger         (trigger),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .sample_strobe   (sample_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic give_up(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at cycle %0d", name, cyc);
        finish_run();
    endtask

    // scoreboard: every strobe consumes one expectation; otherwise outputs must hold the last result
    always @(negedge clk) begin
        if (reset_l) begin
            if (sample_strobe) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    popped = q.pop_front();
                    check("strobe_cycle", cyc, popped.at);
                    check("valid", {31'd0, read_data_valid}, {31'd0, popped.valid});
                    check("distance", {16'd0, read_data}, popped.data);
                    model_data  = popped.data;
                    model_valid = popped.valid;
                end
            end else begin
                check("hold_data", {16'd0, read_data}, model_data);
                check("hold_valid", {31'd0, read_data_valid}, {31'd0, model_valid});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_l) begin
            hi_cnt    = 0;
            last_rise = -1;
            trig_d    = 1'b0;
        end else begin
            if (trigger && !trig_d) begin
                if (last_rise >= 0) check("trig_period", cyc - last_rise, PERIOD_US);
                last_rise = cyc;
                hi_cnt    = 0;
            end
            if (trigger) hi_cnt++;
            if (!trigger && trig_d) check("trig_width", hi_cnt, TRIG_US);
            trig_d = trigger;
        end
    end

    task automatic wait_fall(output int tf);
        int n;
        bit seen_hi;
        n = 0;
        seen_hi = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (trigger) seen_hi = 1'b1;
            else if (seen_hi) break;
            if (n > PERIOD_US + 50) give_up("wait_trigger_fall");
        end
        tf = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > TIMEOUT_US + 100) give_up("wait_strobe");
        end
    endtask

    // d: cycles from trigger fall to echo rise, h: echo high cycles (0 = no echo), stuck: echo high before trigger
    task automatic measure(input int d, input int h, input bit stuck);
        int   tf;
        int   c;
        int   cm;
        exp_t e;
        if (stuck) begin
            @(negedge clk);
            echo = 1'b1;
        end
        wait_fall(tf);
        c = tf + d + h;
        cm = h / CM_US;
        if (!stuck && h > 0 && c + 4 <= tf + TIMEOUT_US) begin
            e = '{1'b1, (cm > MAX_CM) ? MAX_CM : cm, c + 4};
            last_pass = e.data;
        end else begin
            e = '{1'b0, last_pass, tf + TIMEOUT_US};
        end
        q.push_back(e);
        if (!stuck && h > 0) begin
            repeat (d) @(negedge clk);
            echo = 1'b1;
            repeat (h) @(negedge clk);
            echo = 1'b0;
        end
        drain();
        echo = 1'b0;
    endtask

    task automatic release_reset();
        int r;
        int n;
        @(negedge clk);
        reset_l = 1'b1;
        r = cyc;
        n = 0;
        while (!trigger) begin
            @(negedge clk);
            n++;
            if (n > 10) give_up("trigger_after_reset");
        end
        check("trig_after_reset", cyc - r, 2);
    endtask

    task automatic reset_mid_measure();
        int tf;
        wait_fall(tf);
        repeat (50) @(negedge clk);
        echo = 1'b1;
        repeat (300) @(negedge clk);
        #2;
        reset_l = 1'b0;
        echo = 1'b0;
        last_pass   = 0;
        model_data  = 0;
        model_valid = 1'b0;
        #1;
        check("abort_trigger", {31'd0, trigger}, 0);
        check("abort_data", {16'd0, read_data}, 0);
        check("abort_valid", {31'd0, read_data_valid}, 0);
        check("abort_strobe", {31'd0, sample_strobe}, 0);
        repeat (3) @(negedge clk);
        release_reset();
    endtask

    initial begin
        #1;
        check("reset_trigger", {31'd0, trigger}, 0);
        check("reset_data", {16'd0, read_data}, 0);
        check("reset_valid", {31'd0, read_data_valid}, 0);
        check("reset_strobe", {31'd0, sample_strobe}, 0);
        repeat (3) @(negedge clk);
        release_reset();
        measure(100, 580, 1'b0);
        measure(0, 0, 1'b0);
        measure(0, 0, 1'b1);
        measure(20, 57, 1'b0);
        measure(20, 58, 1'b0);
        measure(100, 2800, 1'b0);
        measure(1500, TIMEOUT_US - 4 - 1500, 1'b0);
        measure(1500, TIMEOUT_US - 3 - 1500, 1'b0);
        for (int i = 0; i < 6; i++) measure($urandom_range(1, 300), $urandom_range(2, 2600), 1'b0);
        measure(100, 580, 1'b0);
        reset_mid_measure();
        measure(100, 580, 1'b0);
        check("queue_empty", q.size(), 0);
        finish_run();
    end

    initial begin
        #20_000_000;
        give_up("watchdog");
    end

endmodule
